// File: rtl/tl_chan_buffer.sv
// Two-channel TileLink-UL buffer: independent A (request) and D (response) queues,
// each configurable as a wire passthrough or a circular FIFO with optional flow/pipe.

module tl_chan_queue #(
  parameter int W     = 1,
  parameter int DEPTH = 2,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0,
  parameter int CW    = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_bits,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_bits,
  output logic [CW-1:0] count
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_s;
      assign unused_s  = clock ^ reset;
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
      assign out_bits  = in_bits;
      assign count     = {CW{1'b0}};
    end else begin : g_fifo
      localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

      logic [W-1:0]  mem_r [DEPTH];
      logic [PW-1:0] enq_ptr_r;
      logic [PW-1:0] deq_ptr_r;
      logic [CW-1:0] count_r;
      logic          empty_s;
      logic          full_s;
      logic          bypass_s;
      logic          do_enq_s;
      logic          do_deq_s;

      // Pointers wrap explicitly so DEPTH need not be a power of two.
      function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
      endfunction

      assign empty_s   = (count_r == {CW{1'b0}});
      assign full_s    = (count_r == CW'(DEPTH));
      assign in_ready  = !full_s || ((PIPE != 0) && out_ready);
      assign out_valid = !empty_s || ((FLOW != 0) && in_valid);
      assign out_bits  = ((FLOW != 0) && empty_s) ? in_bits : mem_r[deq_ptr_r];

      // A flow-through beat consumed in the same cycle never touches storage.
      assign bypass_s  = (FLOW != 0) && empty_s && in_valid && out_ready;
      assign do_enq_s  = in_valid && in_ready && !bypass_s;
      assign do_deq_s  = out_valid && out_ready && !bypass_s;
      assign count     = count_r;

      // Pointer and occupancy state.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          enq_ptr_r <= {PW{1'b0}};
          deq_ptr_r <= {PW{1'b0}};
          count_r   <= {CW{1'b0}};
        end else begin
          if (do_enq_s) enq_ptr_r <= wrap_inc(enq_ptr_r);
          if (do_deq_s) deq_ptr_r <= wrap_inc(deq_ptr_r);
          case ({do_enq_s, do_deq_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
          endcase
        end
      end

      // Payload storage; deliberately not reset.
      always_ff @(posedge clock) begin
        if (do_enq_s) mem_r[enq_ptr_r] <= in_bits;
      end
    end
  endgenerate

endmodule

module tl_chan_buffer #(
  parameter int ADDR_W  = 31,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 1,
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int A_FLOW  = 0,
  parameter int D_FLOW  = 0,
  parameter int A_PIPE  = 0,
  parameter int D_PIPE  = 0,
  localparam int MASK_W = DATA_W / 8,
  localparam int A_W    = 3 + 3 + 3 + SRC_W + ADDR_W + MASK_W + DATA_W + 1,
  localparam int D_W    = 3 + 2 + 3 + SRC_W + 1 + DATA_W + 1,
  localparam int A_CW   = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
  localparam int D_CW   = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            a_in_valid,
  output logic            a_in_ready,
  input  logic [A_W-1:0]  a_in_bits,
  output logic            a_out_valid,
  input  logic            a_out_ready,
  output logic [A_W-1:0]  a_out_bits,
  input  logic            d_in_valid,
  output logic            d_in_ready,
  input  logic [D_W-1:0]  d_in_bits,
  output logic            d_out_valid,
  input  logic            d_out_ready,
  output logic [D_W-1:0]  d_out_bits,
  output logic [A_CW-1:0] a_count,
  output logic [D_CW-1:0] d_count
);

  tl_chan_queue #(.W(A_W), .DEPTH(A_DEPTH), .FLOW(A_FLOW), .PIPE(A_PIPE), .CW(A_CW)) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_bits   (a_in_bits),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_bits  (a_out_bits),
    .count     (a_count)
  );

  tl_chan_queue #(.W(D_W), .DEPTH(D_DEPTH), .FLOW(D_FLOW), .PIPE(D_PIPE), .CW(D_CW)) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_bits   (d_in_bits),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_bits  (d_out_bits),
    .count     (d_count)
  );

endmodule

// File: tb/tb_tl_chan_buffer.sv
// Directed bench for tl_chan_buffer: four configurations share one set of inputs,
// each test checks the instance whose configuration it targets.

module tb_tl_chan_buffer;

  localparam int A_W = 78;
  localparam int D_W = 43;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           a_in_valid = 1'b0;
  logic           a_out_ready = 1'b0;
  logic           d_in_valid = 1'b0;
  logic           d_out_ready = 1'b0;
  logic [A_W-1:0] a_in_bits = '0;
  logic [D_W-1:0] d_in_bits = '0;

  logic [3:0]     a_in_ready_w;
  logic [3:0]     a_out_valid_w;
  logic [3:0]     d_in_ready_w;
  logic [3:0]     d_out_valid_w;
  logic [A_W-1:0] a_out_bits_w [4];
  logic [D_W-1:0] d_out_bits_w [4];

  logic [1:0] ac0, dc0, ac1, ac3;
  logic       dc1, dc3, ac2, dc2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  // u0: depth 3 / 3
  tl_chan_buffer #(.A_DEPTH(3), .D_DEPTH(3)) u0 (
    .clock(clock), .reset(reset),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready_w[0]), .a_in_bits(a_in_bits),
    .a_out_valid(a_out_valid_w[0]), .a_out_ready(a_out_ready), .a_out_bits(a_out_bits_w[0]),
    .d_in_valid(d_in_valid), .d_in_ready(d_in_ready_w[0]), .d_in_bits(d_in_bits),
    .d_out_valid(d_out_valid_w[0]), .d_out_ready(d_out_ready), .d_out_bits(d_out_bits_w[0]),
    .a_count(ac0), .d_count(dc0));

  // u1: A depth 2 flow, D depth 1 pipe
  tl_chan_buffer #(.A_DEPTH(2), .A_FLOW(1), .D_DEPTH(1), .D_PIPE(1)) u1 (
    .clock(clock), .reset(reset),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready_w[1]), .a_in_bits(a_in_bits),
    .a_out_valid(a_out_valid_w[1]), .a_out_ready(a_out_ready), .a_out_bits(a_out_bits_w[1]),
    .d_in_valid(d_in_valid), .d_in_ready(d_in_ready_w[1]), .d_in_bits(d_in_bits),
    .d_out_valid(d_out_valid_w[1]), .d_out_ready(d_out_ready), .d_out_bits(d_out_bits_w[1]),
    .a_count(ac1), .d_count(dc1));

  // u2: pure passthrough on both channels
  tl_chan_buffer #(.A_DEPTH(0), .D_DEPTH(0)) u2 (
    .clock(clock), .reset(reset),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready_w[2]), .a_in_bits(a_in_bits),
    .a_out_valid(a_out_valid_w[2]), .a_out_ready(a_out_ready), .a_out_bits(a_out_bits_w[2]),
    .d_in_valid(d_in_valid), .d_in_ready(d_in_ready_w[2]), .d_in_bits(d_in_bits),
    .d_out_valid(d_out_valid_w[2]), .d_out_ready(d_out_ready), .d_out_bits(d_out_bits_w[2]),
    .a_count(ac2), .d_count(dc2));

  // u3: A depth 2 plain, D depth 1 without pipe
  tl_chan_buffer #(.A_DEPTH(2), .D_DEPTH(1)) u3 (
    .clock(clock), .reset(reset),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready_w[3]), .a_in_bits(a_in_bits),
    .a_out_valid(a_out_valid_w[3]), .a_out_ready(a_out_ready), .a_out_bits(a_out_bits_w[3]),
    .d_in_valid(d_in_valid), .d_in_ready(d_in_ready_w[3]), .d_in_bits(d_in_bits),
    .d_out_valid(d_out_valid_w[3]), .d_out_ready(d_out_ready), .d_out_bits(d_out_bits_w[3]),
    .a_count(ac3), .d_count(dc3));

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [A_W-1:0] a_pack(input logic [2:0] op, input logic [30:0] addr);
    return {op, 3'd0, 3'd2, 1'b0, addr, 4'hf, {1'b0, addr}, 1'b0};
  endfunction

  function automatic logic [D_W-1:0] d_pack(input logic [31:0] data);
    return {3'd1, 2'd0, 3'd2, 1'b0, 1'b0, data, 1'b0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    d_in_valid = 1'b0; d_out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int sent, recvd, o1, o3;
    logic [15:0] pat;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_a_count", ac0, 2'd0);
    check_eq("rst_a_valid", a_out_valid_w[0], 1'b0);
    check_eq("rst_a_ready", a_in_ready_w[0], 1'b1);
    check_eq("rst_d_ready", d_in_ready_w[0], 1'b1);
    check_eq("rst_d0_ready_lo", a_in_ready_w[2], 1'b0);
    a_out_ready = 1'b1;
    #1;
    check_eq("rst_d0_ready_hi", a_in_ready_w[2], 1'b1);
    a_out_ready = 1'b0;

    // Fill then drain, depth 3
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_bits  = a_pack(3'd1, 31'(32'h100 + 4 * i));
      #1;
      check_eq("fill_ready", a_in_ready_w[0], 1'b1);
      step();
    end
    a_in_valid = 1'b0;
    #1;
    check_eq("full_ready", a_in_ready_w[0], 1'b0);
    check_eq("full_count", ac0, 2'd3);
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("drain_valid", a_out_valid_w[0], 1'b1);
      check_eq("drain_bits", a_out_bits_w[0], a_pack(3'd1, 31'(32'h100 + 4 * i)));
      step();
    end
    #1;
    check_eq("drain_count", ac0, 2'd0);
    check_eq("drain_empty", a_out_valid_w[0], 1'b0);

    // Wrap, D depth 3 with a fixed irregular out_ready pattern
    do_reset();
    sent  = 0;
    recvd = 0;
    pat   = 16'b1011_0010_1110_0101;
    for (int c = 0; c < 200 && recvd < 10; c++) begin
      d_in_valid  = (sent < 10);
      d_in_bits   = d_pack(32'(sent));
      d_out_ready = pat[c % 16];
      #1;
      if (d_out_valid_w[0] && d_out_ready) begin
        check_eq("wrap_data", d_out_bits_w[0], d_pack(32'(recvd)));
        recvd++;
      end
      if (d_in_valid && d_in_ready_w[0]) sent++;
      step();
    end
    d_in_valid = 1'b0;
    #1;
    check_eq("wrap_recvd", recvd, 10);
    check_eq("wrap_count", dc0, 2'd0);
    check_eq("wrap_no_dup", d_out_valid_w[0], 1'b0);

    // Pipe (u1) vs non-pipe (u3), depth 1, readies high
    do_reset();
    d_in_valid  = 1'b1;
    d_out_ready = 1'b1;
    o1 = 0;
    o3 = 0;
    for (int j = 0; j < 10; j++) begin
      d_in_bits = d_pack(32'(j));
      #1;
      if (d_out_valid_w[1]) begin
        check_eq("pipe_data", d_out_bits_w[1], d_pack(32'(j - 1)));
        o1++;
      end
      if (d_out_valid_w[3]) o3++;
      step();
      check_eq("pipe_count", dc1, 1'b1);
    end
    check_eq("pipe_beats", o1, 9);
    check_eq("nopipe_beats", o3, 5);

    // Flow-through on empty A queue
    do_reset();
    a_in_valid  = 1'b1;
    a_in_bits   = a_pack(3'd4, 31'h200);
    a_out_ready = 1'b1;
    #1;
    check_eq("flow_valid", a_out_valid_w[1], 1'b1);
    check_eq("flow_bits", a_out_bits_w[1], a_pack(3'd4, 31'h200));
    check_eq("noflow_valid", a_out_valid_w[3], 1'b0);
    step();
    a_in_valid = 1'b0;
    #1;
    check_eq("flow_count", ac1, 2'd0);
    check_eq("flow_after", a_out_valid_w[1], 1'b0);

    // Depth-0 passthrough with random traffic
    do_reset();
    for (int c = 0; c < 20; c++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      d_in_valid  = 1'($urandom_range(0, 1));
      d_out_ready = 1'($urandom_range(0, 1));
      a_in_bits   = A_W'({$urandom(), $urandom(), $urandom()});
      d_in_bits   = D_W'({$urandom(), $urandom()});
      #1;
      check_eq("wire_a", {a_out_valid_w[2], a_in_ready_w[2], a_out_bits_w[2]},
               {a_in_valid, a_out_ready, a_in_bits});
      check_eq("wire_d", {d_out_valid_w[2], d_in_ready_w[2], d_out_bits_w[2]},
               {d_in_valid, d_out_ready, d_in_bits});
      check_eq("wire_counts", {ac2, dc2}, 2'b00);
      step();
    end

    // Asynchronous reset mid-burst, A depth 2
    do_reset();
    a_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_in_bits = a_pack(3'd1, 31'(i));
      step();
    end
    #1;
    check_eq("burst_count", ac3, 2'd2);
    check_eq("burst_full", a_in_ready_w[3], 1'b0);
    reset = 1'b1;
    #1;
    check_eq("async_count", ac3, 2'd0);
    check_eq("async_valid", a_out_valid_w[3], 1'b0);
    a_in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    step();
    check_eq("post_rst_ready", a_in_ready_w[3], 1'b1);
    check_eq("post_rst_count", ac3, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
